// File: rtl/spart_fifo.sv
// spart_fifo: FIFO-buffered 16x-oversampling UART
// with an 8-bit processor bus and status register.
module spart_fifo_q #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  count;
    logic         pop_ok;
    logic         push_ok;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Storage array; written only on an accepted push
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Pointer update; one extra bit separates full from empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

module spart_fifo #(
    parameter int          DATA_BITS  = 8,
    parameter int          FIFO_DEPTH = 8,
    parameter int          PARITY_EN  = 0,
    parameter int          PARITY_ODD = 0,
    parameter logic [15:0] DIV_RESET  = 16'd325
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       rda,
    output logic       tbr,
    output logic       txd,
    input  logic       rxd
);
    localparam int NB = DATA_BITS;
    localparam logic PAR = (PARITY_EN != 0);
    localparam logic ODD = (PARITY_ODD != 0);
    localparam logic [2:0] BIT_LAST = 3'(NB - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP
    } state_t;

    logic          bus_rd;
    logic          bus_wr;
    logic [7:0]    rd_data;
    logic [7:0]    status;
    logic [15:0]   db;
    logic [15:0]   db_next;
    logic          db_wr;
    logic [15:0]   baud_cnt;
    logic          tick;

    logic          tx_push;
    logic          tx_pop;
    logic [NB-1:0] tx_head;
    logic          tx_empty;
    logic          tx_full;
    logic          tx_idle;
    state_t        tx_state;
    logic [3:0]    tx_tick;
    logic [2:0]    tx_bit;
    logic [NB-1:0] tx_shift;
    logic          tx_par;

    logic          rx_s1;
    logic          rx_s2;
    logic          rx_q;
    state_t        rx_state;
    logic [3:0]    rx_tick;
    logic [2:0]    rx_bit;
    logic [NB-1:0] rx_shift;
    logic          rx_perr;
    logic          rx_push;
    logic          rx_pop;
    logic [NB-1:0] rx_head;
    logic          rx_empty;
    logic          rx_full;

    logic          ovr;
    logic          perr;
    logic          ferr;
    logic          clr;

    assign bus_rd = iocs && iorw;
    assign bus_wr = iocs && !iorw;
    assign db_wr  = bus_wr && ioaddr[1];
    assign clr    = bus_wr && (ioaddr == 2'b01);

    assign tx_push = bus_wr && (ioaddr == 2'b00);
    assign rx_pop  = bus_rd && (ioaddr == 2'b00);

    assign tx_pop = tick && !tx_empty &&
                    ((tx_state == IDLE) ||
                     ((tx_state == STOP) &&
                      (tx_tick == 4'd15)));

    assign rx_push = tick && (rx_state == STOP) &&
                     (rx_tick == 4'd7);

    assign tx_idle = tx_empty && (tx_state == IDLE);
    assign rda     = !rx_empty;
    assign tbr     = !tx_full;
    assign status  = {2'b00, ferr, perr, ovr,
                      tx_idle, tbr, rda};

    assign tick = (baud_cnt == 16'd0);

    spart_fifo_q #(.W(NB), .DEPTH(FIFO_DEPTH)) u_txq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (tx_push),
        .wdata (databus[NB-1:0]),
        .pop   (tx_pop),
        .head  (tx_head),
        .empty (tx_empty),
        .full  (tx_full)
    );

    spart_fifo_q #(.W(NB), .DEPTH(FIFO_DEPTH)) u_rxq (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rx_push),
        .wdata (rx_shift),
        .pop   (rx_pop),
        .head  (rx_head),
        .empty (rx_empty),
        .full  (rx_full)
    );

    // Divisor value after this cycle's byte writes
    always_comb begin
        db_next = db;
        if (bus_wr && (ioaddr == 2'b10))
            db_next[7:0] = databus;
        if (bus_wr && (ioaddr == 2'b11))
            db_next[15:8] = databus;
    end

    // Read mux; empty RX reads as zero
    always_comb begin
        rd_data = 8'h00;
        unique case (ioaddr)
            2'b00:
                if (!rx_empty)
                    rd_data[NB-1:0] = rx_head;
            2'b01: rd_data = status;
            2'b10: rd_data = db[7:0];
            2'b11: rd_data = db[15:8];
            default: rd_data = 8'h00;
        endcase
    end

    assign databus = bus_rd ? rd_data : 8'hzz;

    // Divisor register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            db <= DIV_RESET;
        else
            db <= db_next;
    end

    // Baud down-counter; a divisor write restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            baud_cnt <= DIV_RESET;
        else if (db_wr)
            baud_cnt <= db_next;
        else if (tick)
            baud_cnt <= db;
        else
            baud_cnt <= baud_cnt - 16'd1;
    end

    // Transmit FSM: 16 ticks per bit, pops on frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= IDLE;
            tx_tick  <= 4'd0;
            tx_bit   <= 3'd0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            txd      <= 1'b1;
        end else if (tick) begin
            tx_tick <= tx_tick + 4'd1;
            unique case (tx_state)
                IDLE: begin
                    tx_tick <= 4'd0;
                    if (!tx_empty) begin
                        tx_shift <= tx_head;
                        tx_par   <= (^tx_head) ^ ODD;
                        tx_bit   <= 3'd0;
                        tx_state <= START;
                        txd      <= 1'b0;
                    end
                end
                START: begin
                    if (tx_tick == 4'd15) begin
                        tx_state <= DATA;
                        txd      <= tx_shift[0];
                    end
                end
                DATA: begin
                    if (tx_tick == 4'd15) begin
                        if (tx_bit == BIT_LAST) begin
                            if (PAR) begin
                                tx_state <= PARITY;
                                txd      <= tx_par;
                            end else begin
                                tx_state <= STOP;
                                txd      <= 1'b1;
                            end
                        end else begin
                            tx_bit   <= tx_bit + 3'd1;
                            tx_shift <= tx_shift >> 1;
                            txd      <= tx_shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (tx_tick == 4'd15) begin
                        tx_state <= STOP;
                        txd      <= 1'b1;
                    end
                end
                STOP: begin
                    if (tx_tick == 4'd15) begin
                        if (!tx_empty) begin
                            tx_shift <= tx_head;
                            tx_par   <= (^tx_head) ^ ODD;
                            tx_bit   <= 3'd0;
                            tx_state <= START;
                            txd      <= 1'b0;
                        end else begin
                            tx_state <= IDLE;
                        end
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // Two-flop synchroniser plus edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_q  <= 1'b1;
        end else begin
            rx_s1 <= rxd;
            rx_s2 <= rx_s1;
            rx_q  <= rx_s2;
        end
    end

    // Receive FSM: state names the next bit to sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= IDLE;
            rx_tick  <= 4'd0;
            rx_bit   <= 3'd0;
            rx_shift <= '0;
            rx_perr  <= 1'b0;
        end else if (rx_state == IDLE) begin
            rx_tick <= 4'd0;
            if (rx_q && !rx_s2)
                rx_state <= START;
        end else if (tick) begin
            rx_tick <= rx_tick + 4'd1;
            if (rx_tick == 4'd7) begin
                unique case (rx_state)
                    START: begin
                        if (rx_s2) begin
                            rx_state <= IDLE;
                        end else begin
                            rx_state <= DATA;
                            rx_bit   <= 3'd0;
                        end
                    end
                    DATA: begin
                        rx_shift <= {rx_s2,
                                     rx_shift[NB-1:1]};
                        if (rx_bit == BIT_LAST)
                            rx_state <= PAR ? PARITY : STOP;
                        else
                            rx_bit <= rx_bit + 3'd1;
                    end
                    PARITY: begin
                        rx_perr  <= rx_s2 !=
                                    ((^rx_shift) ^ ODD);
                        rx_state <= STOP;
                    end
                    default: rx_state <= IDLE;
                endcase
            end
        end
    end

    // Sticky error flags; a same-cycle set wins over clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr  <= 1'b0;
            perr <= 1'b0;
            ferr <= 1'b0;
        end else begin
            ovr  <= (ovr & ~(clr & databus[3])) |
                    (rx_push & rx_full & ~rx_pop);
            perr <= (perr & ~(clr & databus[4])) |
                    (rx_push & PAR & rx_perr);
            ferr <= (ferr & ~(clr & databus[5])) |
                    (rx_push & ~rx_s2);
        end
    end
endmodule

// File: tb/tb_spart_fifo.sv
// tb_spart_fifo: directed bench for spart_fifo with a
// frame-level TX model checked every clock.
module tb_spart_fifo;
    localparam int DEPTH_A = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs;
    logic       rw;
    logic       sel;
    logic [1:0] addr;
    logic [7:0] wd;
    logic       loop;
    logic       rxd_b;
    wire  [7:0] db_a;
    wire  [7:0] db_b;
    logic       iocs_a, iocs_b, rxd_a;
    logic       rda_a, tbr_a, txd_a;
    logic       rda_b, tbr_b, txd_b;

    int n_chk  = 0;
    int n_fail = 0;
    int cur_db = 325;

    assign iocs_a = cs && !sel;
    assign iocs_b = cs && sel;
    assign db_a   = (iocs_a && !rw) ? wd : 8'hzz;
    assign db_b   = (iocs_b && !rw) ? wd : 8'hzz;
    assign rxd_a  = loop ? txd_a : 1'b1;

    always #5 clk = ~clk;

    spart_fifo #(
        .DATA_BITS(8), .FIFO_DEPTH(DEPTH_A),
        .PARITY_EN(0), .PARITY_ODD(0),
        .DIV_RESET(16'd325)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .iocs(iocs_a),
        .iorw(rw), .ioaddr(addr), .databus(db_a),
        .rda(rda_a), .tbr(tbr_a), .txd(txd_a),
        .rxd(rxd_a)
    );

    spart_fifo #(
        .DATA_BITS(8), .FIFO_DEPTH(8),
        .PARITY_EN(1), .PARITY_ODD(0),
        .DIV_RESET(16'd325)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .iocs(iocs_b),
        .iorw(rw), .ioaddr(addr), .databus(db_b),
        .rda(rda_b), .tbr(tbr_b), .txd(txd_b),
        .rxd(rxd_b)
    );

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h @%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic wr(input logic s, input logic [1:0] a,
                      input logic [7:0] d);
        @(negedge clk);
        sel = s; cs = 1'b1; rw = 1'b0; addr = a; wd = d;
        @(negedge clk);
        cs = 1'b0; rw = 1'b1;
    endtask

    task automatic rd(input logic s, input logic [1:0] a,
                      output logic [7:0] d);
        @(negedge clk);
        sel = s; cs = 1'b1; rw = 1'b1; addr = a;
        #1;
        d = s ? db_b : db_a;
        @(negedge clk);
        cs = 1'b0;
    endtask

    task automatic exp_rd(input string name, input logic s,
                          input logic [1:0] a,
                          input logic [7:0] e);
        logic [7:0] d;
        rd(s, a, d);
        check(name, d, e);
    endtask

    task automatic send_b(input logic [10:0] bits);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            rxd_b = bits[i];
            repeat (63) @(negedge clk);
        end
        @(negedge clk);
        rxd_b = 1'b1;
    endtask

    // Frame-level model of TX on dut_a: queue of accepted
    // characters, ideal waveform per frame, tbr from depth.
    logic [7:0] q[$];
    logic [9:0] fbits;
    logic       in_frame = 1'b0;
    int         ft = 0;
    int         idle_wait = 0;

    initial forever begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            q.delete();
            in_frame  = 1'b0;
            idle_wait = 0;
            cur_db    = 325;
            check("txd_rst", txd_a, 1'b1);
        end else begin
            if (in_frame) begin
                ft++;
                if (ft == 10 * 16 * (cur_db + 1)) begin
                    in_frame = 1'b0;
                    if (q.size() > 0)
                        check("b2b", txd_a, 1'b0);
                end else begin
                    check("txd_bit", txd_a,
                          fbits[ft / (16 * (cur_db + 1))]);
                end
            end
            if (!in_frame && txd_a == 1'b0) begin
                if (q.size() == 0) begin
                    check("spurious", 1'b0, 1'b1);
                end else begin
                    fbits = {1'b1, q.pop_front(), 1'b0};
                    in_frame = 1'b1;
                    ft = 0;
                end
            end
            if (iocs_a && !rw && addr == 2'b00)
                if (q.size() < DEPTH_A)
                    q.push_back(wd);
            if (!in_frame && q.size() > 0) begin
                idle_wait++;
                check("tx_lat", idle_wait <= cur_db + 2, 1);
            end else begin
                idle_wait = 0;
            end
            check("tbr", tbr_a, q.size() < DEPTH_A);
        end
    end

    logic exp_a5 [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    initial begin
        bit ok;
        rst_n = 1'b0; cs = 1'b0; rw = 1'b1; sel = 1'b0;
        addr = 2'b00; wd = 8'h00; loop = 1'b0;
        rxd_b = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_txd", txd_a, 1'b1);
        check("rst_rda", rda_a, 1'b0);
        check("rst_tbr", tbr_a, 1'b1);
        check("rst_busz", db_a === 8'hzz, 1'b1);
        rst_n = 1'b1;
        exp_rd("rst_status", 0, 2'b01, 8'h06);
        exp_rd("rst_dblo", 0, 2'b10, 8'h45);
        exp_rd("rst_dbhi", 0, 2'b11, 8'h01);

        // A5 waveform with DB=3
        wr(0, 2'b10, 8'h03);
        wr(0, 2'b11, 8'h00);
        cur_db = 3;
        exp_rd("db3", 0, 2'b10, 8'h03);
        wr(0, 2'b00, 8'hA5);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(posedge clk);
            #2;
            if (txd_a == 1'b0) ok = 1'b1;
        end
        check("a5_start", ok, 1'b1);
        repeat (32) @(posedge clk);
        #2;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("a5_bit%0d", i),
                  txd_a, exp_a5[i]);
            if (i < 9) begin
                repeat (64) @(posedge clk);
                #2;
            end
        end
        repeat (60) @(negedge clk);
        exp_rd("a5_idle", 0, 2'b01, 8'h06);

        // Loopback, two back-to-back frames
        @(negedge clk);
        loop = 1'b1;
        wr(0, 2'b00, 8'h3C);
        wr(0, 2'b00, 8'hC3);
        repeat (1400) @(negedge clk);
        check("lb_rda", rda_a, 1'b1);
        exp_rd("lb_rd1", 0, 2'b00, 8'h3C);
        exp_rd("lb_rd2", 0, 2'b00, 8'hC3);
        @(negedge clk);
        check("lb_rda0", rda_a, 1'b0);
        exp_rd("lb_rd3", 0, 2'b00, 8'h00);

        // TX full drop and RX overrun
        wr(0, 2'b00, 8'h11);
        repeat (10) @(negedge clk);
        wr(0, 2'b00, 8'h22);
        wr(0, 2'b00, 8'h33);
        wr(0, 2'b00, 8'h44);
        wr(0, 2'b00, 8'h55);
        check("ov_tbr0", tbr_a, 1'b0);
        wr(0, 2'b00, 8'h66);
        repeat (3400) @(negedge clk);
        exp_rd("ov_status", 0, 2'b01, 8'h0F);
        wr(0, 2'b01, 8'h08);
        exp_rd("ov_clr", 0, 2'b01, 8'h07);
        exp_rd("ov_rd1", 0, 2'b00, 8'h11);
        exp_rd("ov_rd2", 0, 2'b00, 8'h22);
        exp_rd("ov_rd3", 0, 2'b00, 8'h33);
        exp_rd("ov_rd4", 0, 2'b00, 8'h44);
        exp_rd("ov_empty", 0, 2'b00, 8'h00);
        exp_rd("ov_st2", 0, 2'b01, 8'h06);

        // Parity and framing errors on dut_b
        wr(1, 2'b10, 8'h03);
        wr(1, 2'b11, 8'h00);
        send_b({1'b1, 1'b0, 8'h07, 1'b0});
        repeat (64) @(negedge clk);
        exp_rd("par_status", 1, 2'b01, 8'h17);
        exp_rd("par_data", 1, 2'b00, 8'h07);
        wr(1, 2'b01, 8'h10);
        exp_rd("par_clr", 1, 2'b01, 8'h06);
        send_b({1'b0, 1'b0, 8'h55, 1'b0});
        repeat (128) @(negedge clk);
        exp_rd("frm_status", 1, 2'b01, 8'h27);
        exp_rd("frm_data", 1, 2'b00, 8'h55);
        wr(1, 2'b01, 8'h38);
        exp_rd("frm_clr", 1, 2'b01, 8'h06);

        // Short glitch is a false start
        @(negedge clk);
        rxd_b = 1'b0;
        repeat (3) @(negedge clk);
        rxd_b = 1'b1;
        repeat (200) @(negedge clk);
        check("gl_rda", rda_b, 1'b0);
        exp_rd("gl_status", 1, 2'b01, 8'h06);
        send_b({1'b1, 1'b0, 8'h5A, 1'b0});
        repeat (64) @(negedge clk);
        exp_rd("gl_status2", 1, 2'b01, 8'h07);
        exp_rd("gl_data", 1, 2'b00, 8'h5A);

        // Reset in the middle of a frame
        @(negedge clk);
        loop = 1'b0;
        wr(0, 2'b00, 8'hFF);
        repeat (40) @(posedge clk);
        #3;
        check("pre_rst_txd", txd_a, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_txd", txd_a, 1'b1);
        check("mid_rst_tbr", tbr_a, 1'b1);
        check("mid_rst_rda", rda_a, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_rd("mr_status", 0, 2'b01, 8'h06);
        exp_rd("mr_dblo", 0, 2'b10, 8'h45);
        exp_rd("mr_dbhi", 0, 2'b11, 8'h01);
        check("mr_txd", txd_a, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spart_fifo.md
# spart_fifo

Second-generation SPART: a parametrised, FIFO-buffered, 16x-oversampling UART with an 8-bit processor bus interface. It replaces the single-buffer SPART between the processor's I/O port (iocs/iorw/ioaddr/databus) and the board serial pins. It adds configurable character length, optional parity, TX/RX FIFOs, a status register and sticky error flags.

## Interface
- DATA_BITS, 8: character length, 5..8.
- FIFO_DEPTH, 8: entries per TX and RX FIFO; power of two, at least 2.
- PARITY_EN, 0: 1 inserts and checks a parity bit after the data bits.
- PARITY_ODD, 0: 1 selects odd parity, 0 selects even; ignored when PARITY_EN=0.
- DIV_RESET, 16'd325: reset value of the divisor register DB (50 MHz, 9600 baud, 16x).
- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- iocs  in  1  chip select; each cycle high is one access.
- iorw  in  1  1 = read, 0 = write.
- ioaddr  in  2  register select.
- databus  inout  8  driven only while iocs && iorw; Z otherwise.
- rda  out  1  RX FIFO non-empty.
- tbr  out  1  TX FIFO not full.
- txd  out  1  serial out; idles high.
- rxd  in  1  serial in; asynchronous.

## Operation
- Register map:
  - 00 read: pops the RX FIFO.
  - 00 write: pushes the TX FIFO.
  - 01 read: STATUS.
  - 01 write: write-1-to-clear of error bits [5:3].
  - 10: DB[7:0], read/write.
  - 11: DB[15:8], read/write.
- STATUS bits:
  - [0] rda.
  - [1] tbr.
  - [2] tx_idle: TX FIFO empty and shifter idle.
  - [3] overrun.
  - [4] parity_err.
  - [5] frame_err.
  - [7:6] read as 0.
- RX read data:
  - Addr 00 read data is the FIFO head, zero-extended above DATA_BITS.
  - An empty read returns 8'h00 and does not pop.
- TX write data:
  - Bits [DATA_BITS-1:0] are pushed.
  - A write when the FIFO is full is dropped, with no flag.
- Baud generator:
  - A down-counter loads DB, ticks when it reaches 0, then reloads. Tick period is DB+1 clocks; DB=0 gives a tick every clock.
  - Any DB write reloads the counter on the same edge.
- Frame format: start (0), data LSB first, optional parity, one stop (1). Each bit lasts 16 ticks.
- TX FSM (IDLE, START, DATA, PARITY, STOP):
  - Leaves IDLE on a tick when the FIFO is non-empty; pops the FIFO and loads the shifter.
  - After STOP, goes straight to START if the FIFO is non-empty (no idle bit), else to IDLE.
- RX FSM (IDLE, START, DATA, PARITY, STOP):
  - rxd passes through a 2-flop synchroniser.
  - IDLE→START on a synchronised falling edge; the tick counter resets to 0.
  - Samples at tick 8 of each bit. A start bit sampled high is a false start: return to IDLE, no push.
  - At the STOP sample, the character is pushed.
  - parity_err sets on a parity mismatch; frame_err sets on stop=0. The character is still pushed in both cases.
  - If the RX FIFO is full at push time and not popped that cycle, the character is dropped and overrun sets.
  - RX returns to IDLE right after the stop sample, so it is ready for a new start edge half a bit early.
- Error flags are sticky until W1C or reset. A set event and a clear in the same cycle leave the flag set.
- FIFOs:
  - Circular buffers with log2(FIFO_DEPTH)+1-bit pointers.
  - A push is accepted when count < FIFO_DEPTH, or when a pop occurs in the same cycle.
  - A simultaneous push and pop on an empty FIFO: the pop is ignored and the push is accepted.

## Timing
- Reset values (asynchronous, immediate):
  - txd=1, rda=0, tbr=1, databus=Z.
  - FIFOs empty, DB=DIV_RESET, flags 0, both FSMs IDLE.
  - Reset mid-frame truncates the frame at once; txd returns high.
- Bus writes take effect at the clk edge where iocs && !iorw.
- Reads: databus is valid combinationally in the iocs && iorw cycle. The RX pop and any status side-effects occur at the end of that cycle.
- rda, tbr and STATUS update the cycle after the FIFO edge that changes them.
- TX latency: txd falls on the first tick at least one clock after the push into an idle transmitter. Worst case is DB+2 clocks.
- One TX frame lasts (2+DATA_BITS+PARITY_EN)*16*(DB+1) clocks.
- RX: rda rises 1 clock after the stop-bit sample edge, about 3 clocks of synchroniser plus sample latency after mid-stop.

## Test plan
- Reset, then DB=3 and write 8'hA5:
  - txd shows 0,1,0,1,0,0,1,0,1,1, each bit held 64 clocks.
  - tx_idle returns to 1 after the stop bit.
- Loopback (rxd=txd), DB=3, write 8'h3C then 8'hC3:
  - Frames are back-to-back with no idle gap.
  - rda=1; two reads return 8'h3C then 8'hC3; rda=0; third read returns 8'h00.
- FIFO_DEPTH=4, loopback, 6 characters written while the TX FIFO is full-checked:
  - tbr drops at 4 pending; the 6th write is dropped.
  - With no reads, the 5th received character sets overrun; the FIFO keeps the first 4.
  - Writing 8'h08 to addr 01 clears overrun.
- PARITY_EN=1, PARITY_ODD=0, rxd driven with 8'h07 and parity bit 0:
  - parity_err=1 and 8'h07 is still readable.
  - Frame with stop=0: frame_err=1.
- 3-clock low glitch on rxd, then idle: no push, rda stays 0, RX FSM back in IDLE.
- Assert rst_n low mid-transmission of 8'hFF: txd=1 immediately, tbr=1, STATUS=8'h06, and DB reads back 325.
